// File: rtl/fp_div_pkg.sv
// Shared types and constants for the FP divider post-divide stage.
// FPDIV_DENORM_EN adds the DENORM state used for gradual underflow.
package fp_div_pkg;

  typedef enum logic [1:0] {
    KIND_NORMAL = 2'd0,
    KIND_ZERO   = 2'd1,
    KIND_INF    = 2'd2,
    KIND_NAN    = 2'd3
  } kind_t;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_NORM   = 3'd1,
`ifdef FPDIV_DENORM_EN
    S_DENORM = 3'd2,
`endif
    S_ROUND  = 3'd3,
    S_PACK   = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  // Exponent bias for a given exponent field width.
  function automatic int unsigned bias(input int unsigned exp_w);
    return (32'd1 << (exp_w - 1)) - 32'd1;
  endfunction

  // All-ones biased exponent used by infinities and NaNs.
  function automatic int unsigned exp_max(input int unsigned exp_w);
    return (32'd1 << exp_w) - 32'd1;
  endfunction

endpackage

// File: rtl/fp_rne_rounder.sv
// Combinational round-to-nearest-even on a mantissa with guard and sticky bits.
module fp_rne_rounder #(
  parameter int unsigned MAN_W = 23
) (
  input  logic [MAN_W:0] m,
  input  logic           g,
  input  logic           s,
  output logic [MAN_W:0] m_rnd_c,
  output logic           carry_c,
  output logic           inexact_c
);

  logic up;

  assign up                 = g & (s | m[0]);
  assign {carry_c, m_rnd_c} = {1'b0, m} + (MAN_W + 2)'(up);
  assign inexact_c          = g | s;

endmodule

// File: rtl/fp_div_round_pack.sv
// FP divider post-divide stage: normalize, optional denormalize, RNE round, pack.
// Define FPDIV_DENORM_EN for gradual underflow; otherwise tiny results flush to zero.
module fp_div_round_pack
  import fp_div_pkg::*;
#(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 23,
  parameter int unsigned QW    = MAN_W + 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_sign,
  input  logic [EXP_W+1:0]     in_exp,
  input  logic [1:0]           in_kind,
  input  logic [QW-1:0]        in_quot,
  input  logic                 in_rem_nz,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [EXP_W+MAN_W:0] out_result,
  output logic                 out_ovf,
  output logic                 out_unf,
  output logic                 out_inx
);

  localparam int unsigned MW = MAN_W + 1;
  localparam int unsigned EW = EXP_W + 3;
  localparam int unsigned RW = 1 + EXP_W + MAN_W;
  localparam logic signed [EW-1:0] E_ONE = EW'(1);
  localparam logic signed [EW-1:0] E_MAX = EW'(exp_max(EXP_W));
`ifdef FPDIV_DENORM_EN
  localparam int unsigned CW = $clog2(MAN_W + 3);
  localparam logic [CW-1:0] CNT_CAP = CW'(MAN_W + 2);
`endif

  state_t                state_q, state_d;
  kind_t                 kind_q, kind_d;
  logic                  sign_q, sign_d;
  logic [QW-1:0]         quot_q, quot_d;
  logic                  rem_nz_q, rem_nz_d;
  logic signed [EW-1:0]  e_q, e_d;
  logic [MW-1:0]         m_q, m_d;
  logic                  g_q, g_d;
  logic                  s_q, s_d;
  logic                  tiny_q, tiny_d;
  logic                  inx_q, inx_d;
`ifdef FPDIV_DENORM_EN
  logic [CW-1:0]         cnt_q, cnt_d;
`endif
  logic                  in_ready_d, out_valid_d;
  logic [RW-1:0]         out_result_d;
  logic                  out_ovf_d, out_unf_d, out_inx_d;

  logic                  norm_hi;
  logic [MW-1:0]         norm_m;
  logic                  norm_g, norm_s;
  logic signed [EW-1:0]  norm_e;
  logic [MW-1:0]         rnd_m;
  logic                  rnd_carry, rnd_inx;

  // Leading-one position picks one of two alignments of the quotient.
  always_comb begin
    norm_hi = quot_q[QW-1];
    if (norm_hi) begin
      norm_m = quot_q[QW-1:2];
      norm_g = quot_q[1];
      norm_s = quot_q[0] | rem_nz_q;
      norm_e = e_q;
    end else begin
      norm_m = quot_q[QW-2:1];
      norm_g = quot_q[0];
      norm_s = rem_nz_q;
      norm_e = e_q - E_ONE;
    end
  end

  fp_rne_rounder #(.MAN_W(MAN_W)) u_rnd (
    .m         (m_q),
    .g         (g_q),
    .s         (s_q),
    .m_rnd_c   (rnd_m),
    .carry_c   (rnd_carry),
    .inexact_c (rnd_inx)
  );

  // Next-state, datapath and registered-output logic.
  always_comb begin
    state_d      = state_q;
    kind_d       = kind_q;
    sign_d       = sign_q;
    quot_d       = quot_q;
    rem_nz_d     = rem_nz_q;
    e_d          = e_q;
    m_d          = m_q;
    g_d          = g_q;
    s_d          = s_q;
    tiny_d       = tiny_q;
    inx_d        = inx_q;
`ifdef FPDIV_DENORM_EN
    cnt_d        = cnt_q;
`endif
    out_result_d = out_result;
    out_ovf_d    = out_ovf;
    out_unf_d    = out_unf;
    out_inx_d    = out_inx;

    case (state_q)
      S_IDLE: begin
        if (in_valid && in_ready) begin
          sign_d   = in_sign;
          kind_d   = kind_t'(in_kind);
          quot_d   = in_quot;
          rem_nz_d = in_rem_nz;
          e_d      = {in_exp[EXP_W+1], in_exp};
          state_d  = (kind_t'(in_kind) == KIND_NORMAL) ? S_NORM : S_PACK;
        end
      end
      S_NORM: begin
        m_d    = norm_m;
        g_d    = norm_g;
        s_d    = norm_s;
        e_d    = norm_e;
        tiny_d = (norm_e < E_ONE);
`ifdef FPDIV_DENORM_EN
        cnt_d   = '0;
        state_d = (norm_e < E_ONE) ? S_DENORM : S_ROUND;
`else
        state_d = S_ROUND;
`endif
      end
`ifdef FPDIV_DENORM_EN
      S_DENORM: begin
        m_d   = m_q >> 1;
        g_d   = m_q[0];
        s_d   = s_q | g_q;
        e_d   = e_q + E_ONE;
        cnt_d = cnt_q + CW'(1);
        if ((e_d >= E_ONE) || (cnt_d == CNT_CAP)) begin
          state_d = S_ROUND;
        end
      end
`endif
      S_ROUND: begin
        inx_d   = rnd_inx;
        m_d     = rnd_carry ? {1'b1, rnd_m[MW-1:1]} : rnd_m;
        e_d     = rnd_carry ? (e_q + E_ONE) : e_q;
        state_d = S_PACK;
      end
      S_PACK: begin
        out_ovf_d = 1'b0;
        out_unf_d = 1'b0;
        out_inx_d = 1'b0;
        case (kind_q)
          KIND_ZERO: out_result_d = {sign_q, {(RW-1){1'b0}}};
          KIND_INF:  out_result_d = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
          KIND_NAN:  out_result_d = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
          default: begin
`ifndef FPDIV_DENORM_EN
            if (tiny_q) begin
              out_result_d = {sign_q, {(RW-1){1'b0}}};
              out_unf_d    = 1'b1;
              out_inx_d    = 1'b1;
            end else
`endif
            if (e_q >= E_MAX) begin
              out_result_d = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
              out_ovf_d    = 1'b1;
              out_inx_d    = 1'b1;
            end else begin
              // A cleared hidden bit means a subnormal: exponent field 0.
              out_result_d = {sign_q, (m_q[MAN_W] ? e_q[EXP_W-1:0] : {EXP_W{1'b0}}),
                              m_q[MAN_W-1:0]};
              out_inx_d    = inx_q;
              out_unf_d    = tiny_q & inx_q;
            end
          end
        endcase
        state_d = S_DONE;
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    in_ready_d  = (state_d == S_IDLE);
    out_valid_d = (state_d == S_DONE);
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      kind_q     <= KIND_NORMAL;
      sign_q     <= 1'b0;
      quot_q     <= '0;
      rem_nz_q   <= 1'b0;
      e_q        <= '0;
      m_q        <= '0;
      g_q        <= 1'b0;
      s_q        <= 1'b0;
      tiny_q     <= 1'b0;
      inx_q      <= 1'b0;
`ifdef FPDIV_DENORM_EN
      cnt_q      <= '0;
`endif
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      out_result <= '0;
      out_ovf    <= 1'b0;
      out_unf    <= 1'b0;
      out_inx    <= 1'b0;
    end else begin
      state_q    <= state_d;
      kind_q     <= kind_d;
      sign_q     <= sign_d;
      quot_q     <= quot_d;
      rem_nz_q   <= rem_nz_d;
      e_q        <= e_d;
      m_q        <= m_d;
      g_q        <= g_d;
      s_q        <= s_d;
      tiny_q     <= tiny_d;
      inx_q      <= inx_d;
`ifdef FPDIV_DENORM_EN
      cnt_q      <= cnt_d;
`endif
      in_ready   <= in_ready_d;
      out_valid  <= out_valid_d;
      out_result <= out_result_d;
      out_ovf    <= out_ovf_d;
      out_unf    <= out_unf_d;
      out_inx    <= out_inx_d;
    end
  end

endmodule

// File: tb/tb_fp_div_round_pack.sv
// Directed self-checking bench for fp_div_round_pack (single precision defaults).
module tb_fp_div_round_pack;
  import fp_div_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        in_sign;
  logic [9:0]  in_exp;
  logic [1:0]  in_kind;
  logic [25:0] in_quot;
  logic        in_rem_nz;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_ovf;
  logic        out_unf;
  logic        out_inx;

  int total = 0;
  int bad   = 0;

  fp_div_round_pack dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_sign    (in_sign),
    .in_exp     (in_exp),
    .in_kind    (in_kind),
    .in_quot    (in_quot),
    .in_rem_nz  (in_rem_nz),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_ovf    (out_ovf),
    .out_unf    (out_unf),
    .out_inx    (out_inx)
  );

  always #5 clk = ~clk;

  // Present one operand, then count edges (accept edge = 1) until out_valid; -1 on timeout.
  task automatic send(input logic sgn, input int e, input kind_t k, input int unsigned q,
                      input logic rnz, output int lat);
    in_sign   = sgn;
    in_exp    = 10'(e);
    in_kind   = k;
    in_quot   = 26'(q);
    in_rem_nz = rnz;
    in_valid  = 1'b1;
    @(posedge clk); #1;
    in_valid  = 1'b0;
    lat = 1;
    while (!out_valid && lat < 64) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!out_valid) lat = -1;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_sign = 1'b0;
    in_exp = '0; in_kind = '0; in_quot = '0; in_rem_nz = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    total++; if (out_result !== 32'h0) begin bad++; $display("FAIL reset_result got=%h want=00000000", out_result); end
    total++; if ({out_ovf, out_unf, out_inx} !== 3'b000) begin bad++; $display("FAIL reset_flags got=%b want=000", {out_ovf, out_unf, out_inx}); end
    rst = 1'b0;
  endtask

  task automatic test_exact();
    int lat;
    send(1'b0, 128, KIND_NORMAL, 32'h2000000, 1'b0, lat);
    total++; if (lat !== 4) begin bad++; $display("FAIL six_div_three_latency got=%0d want=4", lat); end
    total++; if (out_result !== 32'h40000000) begin bad++; $display("FAIL six_div_three_result got=%h want=40000000", out_result); end
    total++; if ({out_ovf, out_unf, out_inx} !== 3'b000) begin bad++; $display("FAIL six_div_three_flags got=%b want=000", {out_ovf, out_unf, out_inx}); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL done_in_ready got=%b want=0", in_ready); end
    drain();
    total++; if ({out_valid, in_ready} !== 2'b01) begin bad++; $display("FAIL after_handshake valid_ready got=%b want=01", {out_valid, in_ready}); end
  endtask

  task automatic test_inexact();
    int lat;
    send(1'b0, 126, KIND_NORMAL, 32'h1555555, 1'b1, lat);
    total++; if (out_result !== 32'h3EAAAAAB) begin bad++; $display("FAIL one_third_result got=%h want=3eaaaaab", out_result); end
    total++; if ({out_ovf, out_unf, out_inx} !== 3'b001) begin bad++; $display("FAIL one_third_flags got=%b want=001", {out_ovf, out_unf, out_inx}); end
    drain();
  endtask

  task automatic test_rne();
    int lat;
    send(1'b0, 127, KIND_NORMAL, 32'h2000002, 1'b0, lat);
    total++; if ({out_result, out_inx} !== {32'h3F800000, 1'b1}) begin bad++; $display("FAIL tie_even got=%h/%b want=3f800000/1", out_result, out_inx); end
    drain();
    send(1'b1, 127, KIND_NORMAL, 32'h2000006, 1'b0, lat);
    total++; if ({out_result, out_inx} !== {32'hBF800002, 1'b1}) begin bad++; $display("FAIL tie_odd got=%h/%b want=bf800002/1", out_result, out_inx); end
    drain();
    send(1'b0, 127, KIND_NORMAL, 32'h3FFFFFE, 1'b0, lat);
    total++; if ({out_result, out_inx} !== {32'h40000000, 1'b1}) begin bad++; $display("FAIL round_carry got=%h/%b want=40000000/1", out_result, out_inx); end
    drain();
    send(1'b0, 254, KIND_NORMAL, 32'h3FFFFFE, 1'b0, lat);
    total++; if ({out_result, out_ovf, out_inx} !== {32'h7F800000, 2'b11}) begin bad++; $display("FAIL carry_overflow got=%h/%b%b want=7f800000/11", out_result, out_ovf, out_inx); end
    drain();
  endtask

  task automatic test_overflow();
    int lat;
    send(1'b0, 300, KIND_NORMAL, 32'h2000000, 1'b0, lat);
    total++; if (out_result !== 32'h7F800000) begin bad++; $display("FAIL overflow_result got=%h want=7f800000", out_result); end
    total++; if ({out_ovf, out_unf, out_inx} !== 3'b101) begin bad++; $display("FAIL overflow_flags got=%b want=101", {out_ovf, out_unf, out_inx}); end
    drain();
  endtask

  task automatic test_denormal();
    int lat;
    send(1'b0, -10, KIND_NORMAL, 32'h2000000, 1'b0, lat);
`ifdef FPDIV_DENORM_EN
    total++; if (lat !== 15) begin bad++; $display("FAIL denorm_latency got=%0d want=15", lat); end
    total++; if (out_result !== 32'h00001000) begin bad++; $display("FAIL denorm_result got=%h want=00001000", out_result); end
    total++; if ({out_ovf, out_unf, out_inx} !== 3'b000) begin bad++; $display("FAIL denorm_flags got=%b want=000", {out_ovf, out_unf, out_inx}); end
`else
    total++; if (lat !== 4) begin bad++; $display("FAIL flush_latency got=%0d want=4", lat); end
    total++; if (out_result !== 32'h00000000) begin bad++; $display("FAIL flush_result got=%h want=00000000", out_result); end
    total++; if ({out_ovf, out_unf, out_inx} !== 3'b011) begin bad++; $display("FAIL flush_flags got=%b want=011", {out_ovf, out_unf, out_inx}); end
`endif
    drain();
  endtask

  task automatic test_specials();
    int lat;
    send(1'b1, 0, KIND_ZERO, 32'h0, 1'b0, lat);
    total++; if ({out_result, out_ovf, out_unf, out_inx} !== {32'h80000000, 3'b000}) begin bad++; $display("FAIL neg_zero got=%h/%b want=80000000/000", out_result, {out_ovf, out_unf, out_inx}); end
    drain();
    send(1'b0, 0, KIND_INF, 32'h0, 1'b0, lat);
    total++; if ({out_result, out_ovf, out_unf, out_inx} !== {32'h7F800000, 3'b000}) begin bad++; $display("FAIL pos_inf got=%h/%b want=7f800000/000", out_result, {out_ovf, out_unf, out_inx}); end
    drain();
  endtask

  task automatic test_nan_hold();
    int lat;
    send(1'b1, 0, KIND_NAN, 32'h0, 1'b0, lat);
    total++; if (lat !== 2) begin bad++; $display("FAIL nan_latency got=%0d want=2", lat); end
    total++; if ({out_result, out_ovf, out_unf, out_inx} !== {32'h7FC00000, 3'b000}) begin bad++; $display("FAIL nan_result got=%h/%b want=7fc00000/000", out_result, {out_ovf, out_unf, out_inx}); end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      total++;
      if ({out_valid, in_ready, out_result} !== {2'b10, 32'h7FC00000}) begin
        bad++; $display("FAIL nan_hold cycle=%0d got=%b%b/%h want=10/7fc00000", i, out_valid, in_ready, out_result);
      end
    end
    drain();
    total++; if ({out_valid, out_result} !== {1'b0, 32'h7FC00000}) begin bad++; $display("FAIL nan_retained got=%b/%h want=0/7fc00000", out_valid, out_result); end
  endtask

  task automatic test_reset_mid();
    int lat;
    in_sign = 1'b0; in_exp = 10'(-10); in_kind = KIND_NORMAL; in_quot = 26'h2000000;
    in_rem_nz = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    total++; if ({out_valid, in_ready} !== 2'b01) begin bad++; $display("FAIL midreset_valid_ready got=%b want=01", {out_valid, in_ready}); end
    total++; if (out_result !== 32'h0) begin bad++; $display("FAIL midreset_result got=%h want=00000000", out_result); end
    send(1'b0, 128, KIND_NORMAL, 32'h2000000, 1'b0, lat);
    total++; if ({lat == 4, out_result} !== {1'b1, 32'h40000000}) begin bad++; $display("FAIL after_reset_op got=%0d/%h want=4/40000000", lat, out_result); end
    drain();
  endtask

  initial begin
    test_reset();
    test_exact();
    test_inexact();
    test_rne();
    test_overflow();
    test_denormal();
    test_specials();
    test_nan_hold();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
